// File: rtl/phys_free_list_pkg.sv
// Shared sizing, tag/pointer types and the modulo pointer-add helper for the
// physical register free list.
package phys_free_list_pkg;

  localparam int SIZE_PHYSICAL_TABLE = 96;
  localparam int SIZE_RMT            = 32;
  localparam int PHY_INDEX           = 7;
  localparam int RENAME_WIDTH        = 5;
  localparam int FL_DEPTH            = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int PTR_W               = $clog2(FL_DEPTH);
  localparam int LANE_CNT_W          = $clog2(RENAME_WIDTH + 1);

  typedef logic [PHY_INDEX-1:0]  tag_t;
  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;
  typedef logic [PHY_INDEX:0]    cnt_t;

  // FL_DEPTH need not be a power of two, so wrap with one compare/subtract;
  // base + off always stays below 2*FL_DEPTH.
  function automatic ptr_t wrap_add(input ptr_t base, input lane_cnt_t off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(off);
    if (sum >= (PTR_W+1)'(FL_DEPTH)) sum = sum - (PTR_W+1)'(FL_DEPTH);
    return sum[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/phys_free_list_ptr_offset.sv
// fl_ptr_offset: per-lane compacted pointers (base + prefix popcount, wrapped)
// plus the wrapped pointer after all set lanes and their total count.
module fl_ptr_offset
  import phys_free_list_pkg::*;
(
  input  ptr_t                    base,
  input  logic [RENAME_WIDTH-1:0] vec,
  output ptr_t [RENAME_WIDTH-1:0] lane_ptr,
  output ptr_t                    next_ptr,
  output lane_cnt_t               total
);

  always_comb begin : offsets
    lane_cnt_t acc;
    acc      = '0;
    lane_ptr = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      lane_ptr[k] = wrap_add(base, acc);
      acc         = acc + lane_cnt_t'(vec[k]);
    end
    total    = acc;
    next_ptr = wrap_add(base, acc);
  end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags: up to five zero-latency pops
// per cycle for rename, up to five pushes per cycle from retire.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall_i,
  input  logic [RENAME_WIDTH-1:0]           pop_req_i,
  output logic [RENAME_WIDTH*PHY_INDEX-1:0] tags_o,
  output logic [RENAME_WIDTH-1:0]           pop_valid_o,
  output logic                              free_ok_o,
  input  logic [RENAME_WIDTH-1:0]           push_valid_i,
  input  logic [RENAME_WIDTH*PHY_INDEX-1:0] push_tag_i,
  output logic [PHY_INDEX:0]                free_cnt_o
);

  tag_t entry [FL_DEPTH];
  ptr_t head;
  ptr_t tail;
  cnt_t count;

  ptr_t [RENAME_WIDTH-1:0] pop_ptr;
  ptr_t [RENAME_WIDTH-1:0] push_ptr;
  ptr_t      head_next;
  ptr_t      tail_next;
  lane_cnt_t npop;
  lane_cnt_t npush;
  logic      pop_commit;
  cnt_t      count_next;

  fl_ptr_offset u_pop_offset (
    .base     (head),
    .vec      (pop_req_i),
    .lane_ptr (pop_ptr),
    .next_ptr (head_next),
    .total    (npop)
  );

  fl_ptr_offset u_push_offset (
    .base     (tail),
    .vec      (push_valid_i),
    .lane_ptr (push_ptr),
    .next_ptr (tail_next),
    .total    (npush)
  );

  assign free_ok_o   = cnt_t'(npop) <= count;
  assign pop_valid_o = pop_req_i & {RENAME_WIDTH{free_ok_o}};
  assign pop_commit  = free_ok_o & ~stall_i & (npop != '0);
  assign count_next  = count - (pop_commit ? cnt_t'(npop) : '0) + cnt_t'(npush);
  assign free_cnt_o  = count;

  // Tags come straight from the registered entries; pushes land next edge.
  always_comb begin
    tags_o = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (pop_valid_o[k]) tags_o[k*PHY_INDEX +: PHY_INDEX] = entry[pop_ptr[k]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= cnt_t'(FL_DEPTH);
    end else begin
      if (pop_commit) head <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Architectural tags are held by the map table, so the list starts at NUM_ARCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) entry[i] <= tag_t'(SIZE_RMT + i);
    end else begin
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        if (push_valid_i[k]) entry[push_ptr[k]] <= push_tag_i[k*PHY_INDEX +: PHY_INDEX];
      end
    end
  end

  overflow_chk : assert property (@(posedge clk) disable iff (reset)
                                  count_next <= cnt_t'(FL_DEPTH));

endmodule

// File: tb/tb_phys_free_list.sv
// Directed self-checking bench for phys_free_list.
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  typedef struct {
    int         rep;
    logic [4:0] pop;
    logic [4:0] push;
  } step_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  pop_req = '0;
  logic [4:0]  push_valid = '0;
  logic [34:0] push_tag = '0;
  logic [34:0] tags;
  logic [4:0]  pop_valid;
  logic        free_ok;
  logic [7:0]  free_cnt;
  int total = 0;
  int bad = 0;

  phys_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall),
    .pop_req_i    (pop_req),
    .tags_o       (tags),
    .pop_valid_o  (pop_valid),
    .free_ok_o    (free_ok),
    .push_valid_i (push_valid),
    .push_tag_i   (push_tag),
    .free_cnt_o   (free_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++; if (free_cnt !== 8'd64) begin bad++; $display("FAIL reset_free_cnt got=%0d exp=64", free_cnt); end
    total++; if (free_ok !== 1'b1) begin bad++; $display("FAIL reset_free_ok got=%b exp=1", free_ok); end
    total++; if (pop_valid !== 5'b0) begin bad++; $display("FAIL reset_pop_valid got=%b exp=00000", pop_valid); end
    total++; if (tags !== 35'b0) begin bad++; $display("FAIL reset_tags got=%h exp=0", tags); end
    #1 reset = 1'b0;
  endtask

  task automatic test_full_pop();
    pop_req = 5'b11111;
    #1;
    total++; if (pop_valid !== 5'b11111) begin bad++; $display("FAIL full_pop_valid got=%b exp=11111", pop_valid); end
    total++; if (tags !== {7'd36, 7'd35, 7'd34, 7'd33, 7'd32}) begin bad++; $display("FAIL full_pop_tags got=%h exp=32..36", tags); end
    step();
    pop_req = '0;
    #1;
    total++; if (free_cnt !== 8'd59) begin bad++; $display("FAIL full_pop_cnt got=%0d exp=59", free_cnt); end
  endtask

  task automatic test_sparse_pop();
    pop_req = 5'b10101;
    #1;
    total++; if (pop_valid !== 5'b10101) begin bad++; $display("FAIL sparse_pop_valid got=%b exp=10101", pop_valid); end
    total++; if (tags !== {7'd39, 7'd0, 7'd38, 7'd0, 7'd37}) begin bad++; $display("FAIL sparse_pop_tags got=%h exp=39,0,38,0,37", tags); end
    step();
    pop_req = '0;
    #1;
    total++; if (free_cnt !== 8'd56) begin bad++; $display("FAIL sparse_pop_cnt got=%0d exp=56", free_cnt); end
  endtask

  task automatic test_drain_refuse();
    for (int c = 0; c < 10; c++) begin
      pop_req = 5'b11111;
      #1;
      total++; if (tags[6:0] !== 7'(40 + 5*c)) begin bad++; $display("FAIL drain_tag c=%0d got=%0d exp=%0d", c, tags[6:0], 40 + 5*c); end
      step();
    end
    pop_req = 5'b01111;
    #1;
    total++; if (tags !== {7'd0, 7'd93, 7'd92, 7'd91, 7'd90}) begin bad++; $display("FAIL drain_last_tags got=%h exp=0,93,92,91,90", tags); end
    step();
    pop_req = '0;
    #1;
    total++; if (free_cnt !== 8'd2) begin bad++; $display("FAIL drain_cnt got=%0d exp=2", free_cnt); end
    pop_req = 5'b00111;
    #1;
    total++; if (free_ok !== 1'b0) begin bad++; $display("FAIL refuse_free_ok got=%b exp=0", free_ok); end
    total++; if (pop_valid !== 5'b0) begin bad++; $display("FAIL refuse_pop_valid got=%b exp=00000", pop_valid); end
    total++; if (tags !== 35'b0) begin bad++; $display("FAIL refuse_tags got=%h exp=0", tags); end
    step();
    pop_req = '0;
    #1;
    total++; if (free_cnt !== 8'd2) begin bad++; $display("FAIL refuse_cnt got=%0d exp=2", free_cnt); end
    stall = 1'b1;
    pop_req = 5'b00001;
    #1;
    total++; if (pop_valid !== 5'b00001) begin bad++; $display("FAIL stall_pop_valid got=%b exp=00001", pop_valid); end
    total++; if (tags[6:0] !== 7'd94) begin bad++; $display("FAIL stall_tag got=%0d exp=94", tags[6:0]); end
    step();
    stall = 1'b0;
    pop_req = 5'b00001;
    #1;
    total++; if (free_cnt !== 8'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", free_cnt); end
    total++; if (tags[6:0] !== 7'd94) begin bad++; $display("FAIL stall_head_tag got=%0d exp=94", tags[6:0]); end
    pop_req = '0;
  endtask

  task automatic test_push_pop();
    push_valid = 5'b01011;
    push_tag   = {7'd0, 7'd12, 7'd77, 7'd9, 7'd5};
    pop_req    = 5'b00111;
    #1;
    total++; if (free_ok !== 1'b0) begin bad++; $display("FAIL no_bypass_free_ok got=%b exp=0", free_ok); end
    pop_req = 5'b00011;
    #1;
    total++; if (pop_valid !== 5'b00011) begin bad++; $display("FAIL pushpop_valid got=%b exp=00011", pop_valid); end
    total++; if (tags !== {21'b0, 7'd95, 7'd94}) begin bad++; $display("FAIL pushpop_tags got=%h exp=95,94", tags); end
    step();
    push_valid = '0;
    push_tag   = '0;
    pop_req    = '0;
    #1;
    total++; if (free_cnt !== 8'd3) begin bad++; $display("FAIL pushpop_cnt got=%0d exp=3", free_cnt); end
    pop_req = 5'b00111;
    #1;
    total++; if (tags !== {14'b0, 7'd12, 7'd9, 7'd5}) begin bad++; $display("FAIL pushed_tags got=%h exp=12,9,5", tags); end
    step();
    pop_req = 5'b00001;
    #1;
    total++; if (free_cnt !== 8'd0) begin bad++; $display("FAIL empty_cnt got=%0d exp=0", free_cnt); end
    total++; if (free_ok !== 1'b0) begin bad++; $display("FAIL empty_free_ok got=%b exp=0", free_ok); end
    pop_req = '0;
    #1;
    total++; if (free_ok !== 1'b1) begin bad++; $display("FAIL empty_idle_free_ok got=%b exp=1", free_ok); end
  endtask

  task automatic test_wrap();
    step_t      plan [8];
    logic [6:0] fl_q [$];
    logic [6:0] pool [$];
    logic [6:0] pushed [5];
    logic [6:0] exp_tag;
    plan[0] = '{12, 5'b11111, 5'b00000};
    plan[1] = '{1,  5'b00011, 5'b00000};
    plan[2] = '{1,  5'b00000, 5'b10101};
    plan[3] = '{1,  5'b11111, 5'b00000};
    plan[4] = '{1,  5'b00000, 5'b11111};
    plan[5] = '{11, 5'b11111, 5'b11111};
    plan[6] = '{1,  5'b00000, 5'b11111};
    plan[7] = '{2,  5'b11111, 5'b00000};
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 64; i++) fl_q.push_back(7'(32 + i));
    for (int s = 0; s < 8; s++) begin
      for (int r = 0; r < plan[s].rep; r++) begin
        pop_req    = plan[s].pop;
        push_valid = plan[s].push;
        push_tag   = '0;
        for (int k = 0; k < 5; k++) begin
          pushed[k] = '0;
          if (push_valid[k]) begin
            pushed[k] = pool.pop_front();
            push_tag[k*7 +: 7] = pushed[k];
          end
        end
        #1;
        total++; if (pop_valid !== pop_req) begin bad++; $display("FAIL wrap_valid s=%0d r=%0d got=%b exp=%b", s, r, pop_valid, pop_req); end
        for (int k = 0; k < 5; k++) begin
          exp_tag = '0;
          if (pop_req[k]) begin
            exp_tag = fl_q.pop_front();
            pool.push_back(exp_tag);
          end
          total++; if (tags[k*7 +: 7] !== exp_tag) begin bad++; $display("FAIL wrap_tag s=%0d r=%0d lane=%0d got=%0d exp=%0d", s, r, k, tags[k*7 +: 7], exp_tag); end
        end
        step();
        for (int k = 0; k < 5; k++) if (push_valid[k]) fl_q.push_back(pushed[k]);
        total++; if (free_cnt !== 8'(fl_q.size())) begin bad++; $display("FAIL wrap_cnt s=%0d r=%0d got=%0d exp=%0d", s, r, free_cnt, fl_q.size()); end
      end
    end
    pop_req    = '0;
    push_valid = '0;
    push_tag   = '0;
  endtask

  task automatic test_async_reset();
    push_valid = 5'b11111;
    push_tag   = {7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
    step();
    push_tag = {7'd9, 7'd8, 7'd7, 7'd6, 7'd5};
    pop_req  = 5'b11111;
    #1;
    total++; if (tags !== {7'd4, 7'd3, 7'd2, 7'd1, 7'd0}) begin bad++; $display("FAIL burst_tags got=%h exp=4,3,2,1,0", tags); end
    step();
    push_valid = '0;
    push_tag   = '0;
    #1 reset = 1'b1;
    #1;
    total++; if (free_cnt !== 8'd64) begin bad++; $display("FAIL async_reset_cnt got=%0d exp=64", free_cnt); end
    total++; if (tags[6:0] !== 7'd32) begin bad++; $display("FAIL async_reset_tag got=%0d exp=32", tags[6:0]); end
    #1 reset = 1'b0;
    pop_req = 5'b00001;
    #1;
    total++; if (tags !== {28'b0, 7'd32}) begin bad++; $display("FAIL post_reset_tag got=%h exp=32", tags); end
    total++; if (free_cnt !== 8'd64) begin bad++; $display("FAIL post_reset_cnt got=%0d exp=64", free_cnt); end
    step();
    pop_req = '0;
    #1;
    total++; if (free_cnt !== 8'd63) begin bad++; $display("FAIL post_reset_pop_cnt got=%0d exp=63", free_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_pop();
    test_sparse_pop();
    test_drain_refuse();
    test_push_pop();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
